// File: rtl/uniq_compact_if.sv
// Bus between the sort stage, the sorted-buffer SRAM, the output RAM and uniq_compact.
// slave is the compactor's view; master is the surrounding system's view.
interface uniq_compact_if;
  logic       start;
  logic       SRAM_rd;
  logic [3:0] SRAM_A;
  logic [7:0] SRAM_Q;
  logic       OUT_valid;
  logic [3:0] OUT_A;
  logic [7:0] OUT_D;
  logic [4:0] uniq_cnt;
  logic [4:0] max_run;
  logic       done;

  modport slave (
    input  start, SRAM_Q,
    output SRAM_rd, SRAM_A, OUT_valid, OUT_A, OUT_D, uniq_cnt, max_run, done
  );

  modport master (
    output start, SRAM_Q,
    input  SRAM_rd, SRAM_A, OUT_valid, OUT_A, OUT_D, uniq_cnt, max_run, done
  );
endinterface

// File: rtl/uniq_compact.sv
// Streams a 16-byte sorted buffer and writes each distinct value densely to an output RAM.
// Optional longest-run tracking on max_run is enabled by defining UNIQ_RUNLEN_EN.
module uniq_compact (
  input  logic          clk,
  input  logic          reset_n,
  uniq_compact_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, SCAN, FIN} state_e;

  state_e     state_q;
  logic [3:0] idx_q;
  logic [7:0] prev_q;
  logic [3:0] wptr_q;
  logic       rd_q;
  logic [3:0] addr_q;
  logic       valid_q;
  logic [3:0] out_a_q;
  logic [7:0] out_d_q;
  logic [4:0] cnt_q;
  logic       done_q;
  logic       is_uniq;

  // Element 0 has no predecessor, so it is always written.
  assign is_uniq = (idx_q == 4'd0) || (bus.SRAM_Q != prev_q);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      prev_q  <= '0;
      wptr_q  <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      out_a_q <= '0;
      out_d_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.start) begin
            state_q <= READ;
            rd_q    <= 1'b1;
            addr_q  <= 4'd0;
            idx_q   <= 4'd0;
            wptr_q  <= 4'd0;
            cnt_q   <= 5'd0;
            done_q  <= 1'b0;
          end
        end
        READ: begin
          addr_q  <= 4'd1;
          state_q <= SCAN;
        end
        SCAN: begin
          prev_q <= bus.SRAM_Q;
          if (is_uniq) begin
            valid_q <= 1'b1;
            out_a_q <= wptr_q;
            out_d_q <= bus.SRAM_Q;
            wptr_q  <= wptr_q + 4'd1;
            cnt_q   <= cnt_q + 5'd1;
          end else begin
            valid_q <= 1'b0;
          end
          // Address runs two elements ahead of the data being consumed.
          if (idx_q < 4'd14) begin
            addr_q <= idx_q + 4'd2;
          end else begin
            rd_q <= 1'b0;
          end
          idx_q <= idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          valid_q <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.SRAM_rd   = rd_q;
  assign bus.SRAM_A    = addr_q;
  assign bus.OUT_valid = valid_q;
  assign bus.OUT_A     = out_a_q;
  assign bus.OUT_D     = out_d_q;
  assign bus.uniq_cnt  = cnt_q;
  assign bus.done      = done_q;

`ifdef UNIQ_RUNLEN_EN
  logic [4:0] run_q;
  logic [4:0] max_q;
  logic [4:0] run_d;

  assign run_d = is_uniq ? 5'd1 : run_q + 5'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q <= '0;
      max_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      run_q <= '0;
      max_q <= '0;
    end else if (state_q == SCAN) begin
      run_q <= run_d;
      if (run_d > max_q) begin
        max_q <= run_d;
      end
    end
  end

  assign bus.max_run = max_q;
`else
  assign bus.max_run = '0;
`endif

endmodule

// File: tb/tb_uniq_compact.sv
// Self-checking bench for uniq_compact: table of sorted buffers plus re-pulsed start and mid-run reset.
module tb_uniq_compact;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  uniq_compact_if bus ();

  uniq_compact dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read model of the sorted buffer.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (bus.SRAM_rd) bus.SRAM_Q <= mem[bus.SRAM_A];
  end

  typedef struct {
    logic [15:0][7:0] d;
    int               exp_uniq;
    int               exp_max;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_mem(input logic [15:0][7:0] d);
    for (int k = 0; k < 16; k++) mem[k] = d[k];
  endtask

  task automatic push_expected(input logic [15:0][7:0] d);
    logic [3:0] ptr;
    wr_t w;
    ptr = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (k == 0 || d[k] != d[k-1]) begin
        w.cyc = k + 3;
        w.a   = ptr;
        w.d   = d[k];
        sb.push_back(w);
        ptr = ptr + 4'd1;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sram_rd"},   bus.SRAM_rd,   0);
    check({tag, "_sram_a"},    bus.SRAM_A,    0);
    check({tag, "_out_valid"}, bus.OUT_valid, 0);
    check({tag, "_out_a"},     bus.OUT_A,     0);
    check({tag, "_out_d"},     bus.OUT_D,     0);
    check({tag, "_uniq_cnt"},  bus.uniq_cnt,  0);
    check({tag, "_max_run"},   bus.max_run,   0);
    check({tag, "_done"},      bus.done,      0);
  endtask

  // Start is high in cycle 0; each loop iteration samples cycle c at the falling edge.
  task automatic run_case(input logic [15:0][7:0] d, input int eu, input int em, input int repulse);
    logic [3:0] prev_a;
    logic [7:0] prev_d;
    int         exp_max;
    wr_t        w;
`ifdef UNIQ_RUNLEN_EN
    exp_max = em;
`else
    exp_max = 0;
`endif
    load_mem(d);
    sb.delete();
    push_expected(d);
    @(negedge clk);
    bus.start = 1'b1;
    prev_a = bus.OUT_A;
    prev_d = bus.OUT_D;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == repulse) bus.start = 1'b1;
      if (c == repulse + 1) bus.start = 1'b0;
      check("sram_rd", bus.SRAM_rd, (c <= 16) ? 1 : 0);
      if (c <= 16) check("sram_a", bus.SRAM_A, c - 1);
      if (bus.OUT_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          w = sb.pop_front();
          check("write_cycle", c, w.cyc);
          check("out_a", bus.OUT_A, w.a);
          check("out_d", bus.OUT_D, w.d);
        end
      end else begin
        check("out_a_stable", bus.OUT_A, prev_a);
        check("out_d_stable", bus.OUT_D, prev_d);
      end
      prev_a = bus.OUT_A;
      prev_d = bus.OUT_D;
      if (c == 1) begin
        check("clr_uniq_cnt", bus.uniq_cnt, 0);
        check("clr_max_run",  bus.max_run,  0);
        check("clr_done",     bus.done,     0);
      end
      if (c == 18) check("done_early", bus.done, 0);
      if (c == 19) begin
        check("done_c19",     bus.done,      1);
        check("valid_c19",    bus.OUT_valid, 0);
        check("uniq_cnt",     bus.uniq_cnt,  eu);
        check("max_run",      bus.max_run,   exp_max);
      end
      if (c == 21) begin
        check("done_held",    bus.done,      1);
        check("uniq_held",    bus.uniq_cnt,  eu);
      end
    end
    check("missing_writes", sb.size(), 0);
  endtask

  vec_t vecs[4];

  initial begin
    logic [15:0][7:0] rnd;
    logic [7:0]       t;
    int               ru, rm, run;

    vecs[0].exp_uniq = 16; vecs[0].exp_max = 1;
    vecs[1].exp_uniq = 1;  vecs[1].exp_max = 16;
    vecs[2].exp_uniq = 6;  vecs[2].exp_max = 4;
    vecs[3].exp_uniq = 2;  vecs[3].exp_max = 15;
    for (int k = 0; k < 16; k++) begin
      vecs[0].d[k] = 8'(k);
      vecs[1].d[k] = 8'h55;
      vecs[3].d[k] = (k == 0) ? 8'h00 : 8'hFF;
    end
    vecs[2].d = {8'hFF, 8'hFF, 8'hFF, 8'hF0, 8'hF0, 8'h09, 8'h09, 8'h09,
                 8'h09, 8'h07, 8'h07, 8'h02, 8'h02, 8'h02, 8'h01, 8'h01};

    bus.start  = 1'b0;
    bus.SRAM_Q = 8'h00;
    for (int k = 0; k < 16; k++) mem[k] = 8'h00;

    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("release_done", bus.done, 0);

    for (int i = 0; i < 4; i++) run_case(vecs[i].d, vecs[i].exp_uniq, vecs[i].exp_max, 0);

    // Random sorted buffer; expectations from a small reference walk.
    for (int k = 0; k < 16; k++) rnd[k] = 8'($urandom_range(0, 6));
    for (int i = 1; i < 16; i++) begin
      for (int j = i; j > 0; j--) begin
        if (rnd[j] < rnd[j-1]) begin
          t = rnd[j]; rnd[j] = rnd[j-1]; rnd[j-1] = t;
        end
      end
    end
    ru = 0; rm = 0; run = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 0 || rnd[k] != rnd[k-1]) begin ru++; run = 1; end
      else run++;
      if (run > rm) rm = run;
    end
    run_case(rnd, ru, rm, 0);

    // Start re-pulsed in cycle 8 must be ignored.
    run_case(vecs[2].d, 6, 4, 8);

    // Reset asserted in cycle 10 aborts the run.
    load_mem(vecs[0].d);
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check_all_zero("midrst");
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("midrst_hold_valid", bus.OUT_valid, 0);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("post_rst_valid", bus.OUT_valid, 0);
      check("post_rst_rd",    bus.SRAM_rd,   0);
    end
    check("post_rst_done", bus.done, 0);
    run_case(vecs[2].d, 6, 4, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
